accum_n_bits: RTL and testbench

ACCUM_N_BITS -- requirements
Module: accum_n_bits

---
 rtl/accum_pkg.sv | 18 +
 rtl/en_edge_detect.sv | 33 +++
 rtl/accum_n_bits.sv | 106 ++++++++++
 tb/tb_accum_n_bits.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// -----------------------------------------------------------------------------
// accum_pkg
// Shared constants and helpers for the accum_n_bits accumulator.
//   N_DEFAULT  : default operand/accumulator width in bits
//   EN_Q_RESET : reset value of the En edge-detector history register. It is 1,
//                so an En held high across reset release makes no request.
//   full_add   : 1-bit full adder, returns {carry_out, sum}
// -----------------------------------------------------------------------------
package accum_pkg;

  localparam int   N_DEFAULT  = 8;
  localparam logic EN_Q_RESET = 1'b1;

  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/en_edge_detect.sv
// -----------------------------------------------------------------------------
// en_edge_detect
// Rising-edge detector for the En push-button level. The request is
// combinational, so it is seen at the first Clk edge where En is high and the
// previous sample was low.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (history forced to EN_Q_RESET)
//   en    : level input
//   req   : en & ~en_q, one cycle per low-to-high transition of en
// -----------------------------------------------------------------------------
module en_edge_detect
  import accum_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic req
);

  logic en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= EN_Q_RESET;
    end else begin
      en_q <= en;
    end
  end

  assign req = en & ~en_q;

endmodule

// File: rtl/accum_n_bits.sv
// -----------------------------------------------------------------------------
// accum_n_bits
// Two-stage accumulator driven by a push-button. A rising edge on En captures
// A into a_reg (stage 1, p1 set); the next edge adds a_reg into S (stage 2)
// and pulses Valid. Carry and Overflow are sticky until Clr or reset. Clr is
// synchronous and outranks everything, discarding any pending add.
// Build option: define ACCUM_SAT_EN to saturate S to all ones on carry-out
// instead of wrapping.
// Ports:
//   Clk      : rising-edge clock
//   Resetn   : asynchronous active-low reset
//   A        : operand (N bits)
//   En       : accumulate request level
//   Clr      : synchronous clear of S and flags
//   S        : registered accumulated sum (N bits)
//   Carry    : sticky unsigned carry-out
//   Overflow : sticky two's-complement overflow
//   Valid    : one-cycle pulse after S is updated by an accumulation
// -----------------------------------------------------------------------------
module accum_n_bits
  import accum_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         Clk,
  input  logic         Resetn,
  input  logic [N-1:0] A,
  input  logic         En,
  input  logic         Clr,
  output logic [N-1:0] S,
  output logic         Carry,
  output logic         Overflow,
  output logic         Valid
);

  logic         req;
  logic         p1;
  logic [N-1:0] a_reg;
  logic [N:0]   c;
  logic [N-1:0] sum;
  logic [N-1:0] s_next;
  logic         ovf;

  en_edge_detect u_edge (
    .clk   (Clk),
    .rst_n (Resetn),
    .en    (En),
    .req   (req)
  );

  // Stage 1: operand capture.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      a_reg <= '0;
      p1    <= 1'b0;
    end else if (Clr) begin
      p1 <= 1'b0;
    end else if (req) begin
      a_reg <= A;
      p1    <= 1'b1;
    end else begin
      p1 <= 1'b0;
    end
  end

  // Ripple-carry adder built from 1-bit full adders.
  always_comb begin
    c    = '0;
    sum  = '0;
    for (int i = 0; i < N; i++) begin
      {c[i+1], sum[i]} = full_add(S[i], a_reg[i], c[i]);
    end
  end

  // Signed overflow: operands share a sign that the result does not.
  assign ovf = (S[N-1] == a_reg[N-1]) && (sum[N-1] != S[N-1]);

`ifdef ACCUM_SAT_EN
  assign s_next = c[N] ? {N{1'b1}} : sum;
`else
  assign s_next = sum;
`endif

  // Stage 2: accumulate and flag update.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      S        <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Valid    <= 1'b0;
    end else if (Clr) begin
      S        <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      Valid    <= 1'b0;
    end else if (p1) begin
      S        <= s_next;
      Carry    <= Carry | c[N];
      Overflow <= Overflow | ovf;
      Valid    <= 1'b1;
    end else begin
      Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accum_n_bits.sv
module tb_accum_n_bits;

  localparam int N = 8;

  logic         Clk = 1'b0;
  logic         Resetn;
  logic [N-1:0] A;
  logic         En;
  logic         Clr;
  logic [N-1:0] S;
  logic         Carry;
  logic         Overflow;
  logic         Valid;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: accumulator value and sticky flags.
  logic [N-1:0] s_m;
  logic         carry_m;
  logic         ovf_m;
  logic [N-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  accum_n_bits #(.N(N)) dut (
    .Clk      (Clk),
    .Resetn   (Resetn),
    .A        (A),
    .En       (En),
    .Clr      (Clr),
    .S        (S),
    .Carry    (Carry),
    .Overflow (Overflow),
    .Valid    (Valid)
  );

  // ---------------- reference model ----------------
  task automatic model_clear();
    s_m     = '0;
    carry_m = 1'b0;
    ovf_m   = 1'b0;
  endtask

  task automatic model_add(input logic [N-1:0] a);
    int us;
    int ss;
    us = int'(s_m) + int'(a);
    ss = int'($signed(s_m)) + int'($signed(a));
    if (ss > (1 << (N - 1)) - 1 || ss < -(1 << (N - 1))) ovf_m = 1'b1;
    if (us >= (1 << N)) begin
      carry_m = 1'b1;
`ifdef ACCUM_SAT_EN
      s_m = {N{1'b1}};
`else
      s_m = us[N-1:0];
`endif
    end else begin
      s_m = us[N-1:0];
    end
  endtask

  // ---------------- drivers ----------------
  // One accumulate request: En high for one edge (capture), low for the next
  // (add). Returns Valid sampled after each of those two edges.
  task automatic pulse_req(input logic [N-1:0] a, output logic v_cap, output logic v_add);
    @(negedge Clk);
    A  = a;
    En = 1'b1;
    @(posedge Clk); #1;
    v_cap = Valid;
    @(negedge Clk);
    En = 1'b0;
    @(posedge Clk); #1;
    v_add = Valid;
  endtask

  task automatic do_clear();
    @(negedge Clk);
    Clr = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    Clr = 1'b0;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Resetn = 1'b0;
    En     = 1'b0;
    Clr    = 1'b0;
    A      = '0;
    model_clear();
    #22;
    vectors++;
    if ({S, Carry, Overflow, Valid} !== {{N{1'b0}}, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_state: got S=%h C=%b O=%b V=%b, want all zero", S, Carry, Overflow, Valid);
    end
    @(negedge Clk);
    Resetn = 1'b1;
    @(posedge Clk); #1;
    vectors++;
    if ({S, Valid} !== {{N{1'b0}}, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_release: got S=%h V=%b, want S=00 V=0", S, Valid);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] vals[2];
    logic vc, va;
    vals[0] = 8'h05;
    vals[1] = 8'h03;
    for (int i = 0; i < 2; i++) begin
      pulse_req(vals[i], vc, va);
      model_add(vals[i]);
      vectors++;
      if ({vc, va} !== 2'b01) begin
        miscompares++;
        $display("FAIL basic_valid_%0d: got cap=%b add=%b, want cap=0 add=1", i, vc, va);
      end
      vectors++;
      if ({S, Carry, Overflow} !== {s_m, carry_m, ovf_m}) begin
        miscompares++;
        $display("FAIL basic_sum_%0d: got S=%h C=%b O=%b, want S=%h C=%b O=%b",
                 i, S, Carry, Overflow, s_m, carry_m, ovf_m);
      end
    end
    vectors++;
    if ({S, Carry, Overflow} !== {8'h08, 2'b00}) begin
      miscompares++;
      $display("FAIL basic_total: got S=%h C=%b O=%b, want S=08 C=0 O=0", S, Carry, Overflow);
    end
  endtask

  task automatic test_carry();
    logic vc, va;
    logic [N-1:0] want_s;
    do_clear();
    pulse_req(8'hF0, vc, va);
    model_add(8'hF0);
    pulse_req(8'h20, vc, va);
    model_add(8'h20);
`ifdef ACCUM_SAT_EN
    want_s = 8'hFF;
`else
    want_s = 8'h10;
`endif
    vectors++;
    if ({S, Carry, Overflow, va} !== {want_s, 1'b1, ovf_m, 1'b1}) begin
      miscompares++;
      $display("FAIL carry_out: got S=%h C=%b O=%b V=%b, want S=%h C=1 O=%b V=1",
               S, Carry, Overflow, va, want_s, ovf_m);
    end
    pulse_req(8'h01, vc, va);
    model_add(8'h01);
    vectors++;
    if ({S, Carry} !== {s_m, 1'b1}) begin
      miscompares++;
      $display("FAIL carry_sticky: got S=%h C=%b, want S=%h C=1", S, Carry, s_m);
    end
  endtask

  task automatic test_overflow();
    logic vc, va;
    do_clear();
    pulse_req(8'h7F, vc, va);
    model_add(8'h7F);
    pulse_req(8'h01, vc, va);
    model_add(8'h01);
    vectors++;
    if ({S, Carry, Overflow} !== {8'h80, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL overflow_set: got S=%h C=%b O=%b, want S=80 C=0 O=1", S, Carry, Overflow);
    end
    pulse_req(8'h00, vc, va);
    model_add(8'h00);
    vectors++;
    if ({S, Carry, Overflow, va} !== {8'h80, 1'b0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL overflow_sticky: got S=%h C=%b O=%b V=%b, want S=80 C=0 O=1 V=1",
               S, Carry, Overflow, va);
    end
  endtask

  task automatic test_hold();
    int pulses;
    do_clear();
    pulses = 0;
    @(negedge Clk);
    A  = 8'h01;
    En = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (Valid) pulses++;
    end
    @(negedge Clk);
    En = 1'b0;
    @(posedge Clk); #1;
    if (Valid) pulses++;
    model_add(8'h01);
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL hold_pulses: got %0d Valid pulses, want 1", pulses);
    end
    vectors++;
    if (S !== 8'h01) begin
      miscompares++;
      $display("FAIL hold_sum: got S=%h, want S=01", S);
    end
  endtask

  task automatic test_clr_pending();
    int pulses;
    do_clear();
    pulses = 0;
    @(negedge Clk);
    A  = 8'h09;
    En = 1'b1;
    @(posedge Clk); #1;       // captured, add pending
    if (Valid) pulses++;
    @(negedge Clk);
    Clr = 1'b1;
    @(posedge Clk); #1;
    if (Valid) pulses++;
    @(negedge Clk);
    Clr = 1'b0;
    En  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      if (Valid) pulses++;
    end
    model_clear();
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL clr_pending_valid: got %0d Valid pulses, want 0", pulses);
    end
    vectors++;
    if ({S, Carry, Overflow} !== {8'h00, 2'b00}) begin
      miscompares++;
      $display("FAIL clr_pending_state: got S=%h C=%b O=%b, want S=00 C=0 O=0", S, Carry, Overflow);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic vc, va;
    do_clear();
    pulses = 0;
    @(negedge Clk);
    A  = 8'h07;
    En = 1'b1;
    @(posedge Clk); #1;       // captured
    Resetn = 1'b0;
    #1;
    vectors++;
    if ({S, Carry, Overflow, Valid} !== {{N{1'b0}}, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_mid_async: got S=%h C=%b O=%b V=%b, want all zero", S, Carry, Overflow, Valid);
    end
    @(negedge Clk);
    Resetn = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      if (Valid) pulses++;
    end
    vectors++;
    if ({pulses != 0, S} !== {1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_mid_held: got pulses=%0d S=%h, want pulses=0 S=00", pulses, S);
    end
    @(negedge Clk);
    En = 1'b0;
    pulse_req(8'h07, vc, va);
    model_add(8'h07);
    vectors++;
    if ({S, va} !== {s_m, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_mid_rearm: got S=%h V=%b, want S=%h V=1", S, va, s_m);
    end
  endtask

  task automatic test_back_to_back();
    logic vc, va;
    logic [N-1:0] a;
    logic [N-1:0] exp_s;
    do_clear();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_clear();
        vectors++;
        if ({S, Carry, Overflow} !== {{N{1'b0}}, 2'b00}) begin
          miscompares++;
          $display("FAIL b2b_clear_%0d: got S=%h C=%b O=%b, want zero", i, S, Carry, Overflow);
        end
      end
      a = N'($urandom);
      model_add(a);
      exp_q.push_back(s_m);
      pulse_req(a, vc, va);
      exp_s = exp_q.pop_front();
      vectors++;
      if ({vc, va, S, Carry, Overflow} !== {2'b01, exp_s, carry_m, ovf_m}) begin
        miscompares++;
        $display("FAIL b2b_add_%0d: A=%h got V=%b%b S=%h C=%b O=%b, want V=01 S=%h C=%b O=%b",
                 i, a, vc, va, S, Carry, Overflow, exp_s, carry_m, ovf_m);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_hold();
    test_clr_pending();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
